// File: rtl/barrel_rotator_pipe.sv
// barrel_rotator_pipe: two-stage valid/ready pipelined rotator/reverser on a WIDTH-bit word.
//
// Modes (in_mode): 00 rotate left, 01 rotate right, 10 bit-reverse, 11 reverse then rotate left.
// Stage 1 captures the operand, mode and amount on an input transfer. Stage 2 applies the mode
// and registers the result. Fixed 2-cycle latency, one result per cycle when out_ready is held.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready never depends on in_valid
//   in_data, in_mode      operand and operation select
//   in_amt                rotate amount (0..WIDTH-1), ignored for plain reverse
//   out_valid/out_ready   output handshake
//   out_data              registered result
//   out_parity            XOR of out_data, only when ROT_PARITY_EN is defined
//
// Optional feature macro: ROT_PARITY_EN (adds the registered out_parity output).

module barrel_rotator_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ROT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    ModeRotl    = 2'b00,
    ModeRotr    = 2'b01,
    ModeRev     = 2'b10,
    ModeRevRotl = 2'b11
  } mode_e;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                            input logic [AMT_W-1:0] amt);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} << amt;
    return dd[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] d,
                                            input logic [AMT_W-1:0] amt);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} >> amt;
    return dd[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [1:0]       s1_mode_q;
  logic [AMT_W-1:0] s1_amt_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] result;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    result = s1_data_q;
    unique case (mode_e'(s1_mode_q))
      ModeRotl:    result = rotl(s1_data_q, s1_amt_q);
      ModeRotr:    result = rotr(s1_data_q, s1_amt_q);
      ModeRev:     result = rev(s1_data_q);
      ModeRevRotl: result = rotl(rev(s1_data_q), s1_amt_q);
      default:     result = s1_data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_amt_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_mode_q <= in_mode;
        s1_amt_q  <= in_amt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= result;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

`ifdef ROT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      parity_q <= ^result;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Directed self-checking bench for barrel_rotator_pipe (WIDTH=8).

module tb_barrel_rotator_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef ROT_PARITY_EN
  logic             out_parity;
`endif

  barrel_rotator_pipe #(
    .WIDTH(WIDTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ROT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Vector table: operand, mode, amount, hand-computed result.
  logic [7:0] vd[4];
  logic [1:0] vm[4];
  logic [2:0] va[4];
  logic [7:0] ve[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] d, input logic [1:0] m,
                         input logic [2:0] a, input logic [7:0] e);
    vd[i] = d;
    vm[i] = m;
    va[i] = a;
    ve[i] = e;
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    in_data  = vd[i];
    in_mode  = vm[i];
    in_amt   = va[i];
  endtask

  // Back-to-back stream of n table entries; each result must appear exactly 2 edges later.
  task automatic run_burst(input string name, input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(i);
      else in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (i == 0) begin
        check_eq({name, "_latency"}, 32'(out_valid), 32'd0);
      end else begin
        check_eq({name, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({name, "_data"}, 32'(out_data), 32'(ve[i-1]));
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    int         ri;
    int         extra;
    int         seen;
    logic       acc;
    logic       oacc;
    logic [7:0] od;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    in_amt    = '0;
    out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // All modes back-to-back
    set_vec(0, 8'b1000_0011, 2'b00, 3'd1, 8'b0000_0111);
    set_vec(1, 8'b1111_0000, 2'b01, 3'd2, 8'b0011_1100);
    set_vec(2, 8'b1101_0100, 2'b10, 3'd5, 8'b0010_1011);
    set_vec(3, 8'b1000_0000, 2'b11, 3'd3, 8'b0000_1000);
    run_burst("modes", 4);

    // Amount boundaries
    set_vec(0, 8'b1011_0001, 2'b00, 3'd0, 8'b1011_0001);
    set_vec(1, 8'b1011_0001, 2'b01, 3'd7, 8'b0110_0011);
    set_vec(2, 8'b0000_0001, 2'b00, 3'd7, 8'b1000_0000);
    run_burst("bound", 3);

    // Backpressure: fill both stages, stall the consumer for 3 cycles
    set_vec(0, 8'b1000_0011, 2'b00, 3'd1, 8'b0000_0111);
    set_vec(1, 8'b1111_0000, 2'b01, 3'd2, 8'b0011_1100);
    set_vec(2, 8'b1101_0100, 2'b10, 3'd0, 8'b0010_1011);
    set_vec(3, 8'b1000_0000, 2'b11, 3'd3, 8'b0000_1000);
    drive(0);
    @(posedge clk);
    #1;
    drive(1);
    @(posedge clk);
    #1;
    check_eq("bp_first_valid", 32'(out_valid), 32'd1);
    check_eq("bp_first_data", 32'(out_data), 32'(ve[0]));
    out_ready = 1'b0;
    drive(2);
    #1;
    check_eq("bp_in_ready_full", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_data", 32'(out_data), 32'(ve[0]));
      check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    idx = 2;
    ri  = 0;
    for (int c = 0; c < 30 && ri < 4; c++) begin
      if (idx < 4) drive(idx);
      else in_valid = 1'b0;
      #1;
      acc  = in_valid && in_ready;
      oacc = out_valid && out_ready;
      od   = out_data;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (oacc) begin
        check_eq("bp_order", 32'(od), 32'(ve[ri]));
        ri++;
      end
    end
    in_valid = 1'b0;
    check_eq("bp_count", 32'(ri), 32'd4);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) extra++;
      @(posedge clk);
      #1;
    end
    check_eq("bp_no_dup", 32'(extra), 32'd0);

    // Reset with words in flight
    set_vec(0, 8'b0000_0001, 2'b00, 3'd7, 8'b1000_0000);
    set_vec(1, 8'b1011_0001, 2'b01, 3'd7, 8'b0110_0011);
    drive(0);
    @(posedge clk);
    #1;
    drive(1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check_eq("rst_mid_no_output", 32'(seen), 32'd0);
    check_eq("rst_mid_data", 32'(out_data), 32'd0);

`ifdef ROT_PARITY_EN
    set_vec(0, 8'b1101_0100, 2'b10, 3'd0, 8'b0010_1011);
    set_vec(1, 8'b0000_0111, 2'b00, 3'd0, 8'b0000_0111);
    for (int i = 0; i < 2; i++) begin
      drive(i);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("par_data", 32'(out_data), 32'(ve[i]));
      check_eq("par_bit", 32'(out_parity), (i == 0) ? 32'd0 : 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
